// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake state, arbiter FSM states and arbiter defaults.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int          TIMEOUT_CYC_DEFAULT = 64;
  localparam logic [31:0] BAD_WORD_DEFAULT    = 32'hBAD1BAD1;

endpackage

// File: rtl/arb_timeout_counter.sv
// Watchdog for a granted RAM access: clear/enable counter that saturates at LIMIT-1 and flags done there.
module arb_timeout_counter #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int          W    = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between imem and dmem: registered grant, one access at a time, watchdog error completion.
// Option MEM_ARB_RR_EN: round-robin between simultaneous requests instead of fixed dmem priority.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter logic [31:0] BAD_WORD    = BAD_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  arb_state_t state, next_state;
  ramstate_t  rs;
  logic       dreq;
  logic       live;
  logic       hit;
  logic       fault;
  logic       done;
  logic       tmr_clr;
  logic       tmr_en;
  logic       tmo;

  assign rs   = ramstate_t'(ramstate);
  assign dreq = dREN | dWEN;

  // A grant only completes while its requester still holds the request; otherwise it is an abort.
  assign live  = ((state == IGNT) && iREN) || ((state == DGNT) && dreq);
  assign hit   = live && (rs == ACCESS);
  assign fault = live && !hit && ((rs == ERROR) || tmo);
  assign done  = hit || fault;

  assign tmr_clr = (state == IDLE);
  assign tmr_en  = (state != IDLE) && !done;

  arb_timeout_counter #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .done  (tmo)
  );

`ifdef MEM_ARB_RR_EN
  logic last_d;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      last_d <= 1'b0;
    end else if ((state == IDLE) && (next_state != IDLE)) begin
      last_d <= (next_state == DGNT);
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iload      = '0;
    dload      = '0;
    case (state)
      IDLE: begin
        if (dreq && iREN) begin
`ifdef MEM_ARB_RR_EN
          next_state = last_d ? IGNT : DGNT;
`else
          next_state = DGNT;
`endif
        end else if (dreq) begin
          next_state = DGNT;
        end else if (iREN) begin
          next_state = IGNT;
        end
      end
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (hit) begin
          iload = ramload;
        end else if (fault) begin
          iload = BAD_WORD;
        end
        if (!live || done) begin
          next_state = IDLE;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = !dWEN;
        if (hit) begin
          dload = dWEN ? '0 : ramload;
        end else if (fault) begin
          dload = BAD_WORD;
        end
        if (!live || done) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign err   = fault;
  assign iwait = iREN && !((state == IGNT) && done);
  assign dwait = dreq && !((state == DGNT) && done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a per-owner/age reference model.
module tb_mem_arbiter;

  localparam int          TO    = 4;
  localparam logic [31:0] BAD   = 32'hBAD1BAD1;
  localparam logic [1:0]  S_FREE = 2'd0;
  localparam logic [1:0]  S_BUSY = 2'd1;
  localparam logic [1:0]  S_ACC  = 2'd2;
  localparam logic [1:0]  S_ERR  = 2'd3;

  logic        CLK, nRST, iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Model: who owns the RAM (0 none, 1 imem, 2 dmem), how long it has waited, who was served last.
  int owner  = 0;
  int age    = 0;
  bit last_d = 1'b0;
  bit m_live, m_done;

  mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples at the falling edge and compares every output with the model's expectation.
  task automatic sample();
    logic        dreq, hit, bad, e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_ra, e_rs, e_il, e_dl;
    @(negedge CLK);
    dreq   = dREN || dWEN;
    m_live = (owner == 1 && iREN) || (owner == 2 && dreq);
    hit    = m_live && (ramstate == S_ACC);
    bad    = m_live && !hit && (ramstate == S_ERR || age == TO - 1);
    m_done = hit || bad;
    e_ren = 0; e_wen = 0; e_ra = 0; e_rs = 0; e_il = 0; e_dl = 0;
    if (owner == 1) begin
      e_ren = 1;
      e_ra  = iaddr;
      e_il  = hit ? ramload : (bad ? BAD : 32'h0);
    end else if (owner == 2) begin
      e_ra  = daddr;
      e_rs  = dstore;
      e_wen = dWEN;
      e_ren = !dWEN;
      e_dl  = hit ? (dWEN ? 32'h0 : ramload) : (bad ? BAD : 32'h0);
    end
    e_iw = iREN && !(owner == 1 && m_done);
    e_dw = dreq && !(owner == 2 && m_done);
    check("model_flags", {27'h0, iwait, dwait, ramREN, ramWEN, err},
          {27'h0, e_iw, e_dw, e_ren, e_wen, bad});
    check("model_ramaddr", ramaddr, e_ra);
    check("model_ramstore", ramstore, e_rs);
    check("model_iload", iload, e_il);
    check("model_dload", dload, e_dl);
  endtask

  // Moves the model across the rising edge using the inputs held at that edge.
  task automatic advance();
    bit dreq;
    dreq = dREN || dWEN;
    if (!nRST) begin
      owner = 0; age = 0; last_d = 0;
    end else if (owner == 0) begin
      if (dreq && iREN) begin
`ifdef MEM_ARB_RR_EN
        owner = last_d ? 1 : 2;
`else
        owner = 2;
`endif
      end else if (dreq) owner = 2;
      else if (iREN) owner = 1;
      if (owner != 0) last_d = (owner == 2);
      age = 0;
    end else if (!m_live || m_done) begin
      owner = 0; age = 0;
    end else if (age < TO - 1) begin
      age++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  initial begin
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = S_FREE;
    @(posedge CLK); #1;

    // Reset state
    sample();
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_err", err, 0);
    advance();

    // 1: instruction read, ACCESS on third cycle
    nRST = 1; iREN = 1; iaddr = 32'h40;
    sample(); check("t1_c0_ramREN", ramREN, 0); check("t1_c0_iwait", iwait, 1); advance();
    sample(); check("t1_c1_ramREN", ramREN, 1); check("t1_c1_ramaddr", ramaddr, 32'h40); advance();
    ramstate = S_BUSY; cyc();
    ramstate = S_ACC; ramload = 32'h2402000A;
    sample(); check("t1_c3_iwait", iwait, 0); check("t1_c3_iload", iload, 32'h2402000A); advance();
    iREN = 0; ramstate = S_FREE;
    sample(); check("t1_bubble_ramREN", ramREN, 0); advance();

    // 2: simultaneous requests, dmem served first, bubble, then imem
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h200;
    cyc();
    ramstate = S_ACC; ramload = 32'h11111111;
    sample(); check("t2_d_first", ramaddr, 32'h200); check("t2_d_dwait", dwait, 0);
    check("t2_d_dload", dload, 32'h11111111); check("t2_i_waits", iwait, 1); advance();
    dREN = 0; ramstate = S_FREE;
    sample(); check("t2_bubble", ramREN, 0); advance();
    ramstate = S_ACC; ramload = 32'h22222222;
    sample(); check("t2_i_addr", ramaddr, 32'h44); check("t2_i_iload", iload, 32'h22222222); advance();
    iREN = 0; ramstate = S_FREE; cyc();

    // 3: write wins over read
    dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    cyc();
    sample(); check("t3_ramWEN", ramWEN, 1); check("t3_ramREN", ramREN, 0);
    check("t3_ramstore", ramstore, 32'hDEADBEEF); check("t3_dwait_hold", dwait, 1); advance();
    ramstate = S_ACC;
    sample(); check("t3_dwait_drop", dwait, 0); check("t3_dload_zero", dload, 0); advance();
    dWEN = 0; dREN = 0; ramstate = S_FREE; cyc();

    // 4: BUSY forever -> timeout on fourth grant cycle
    dREN = 1; daddr = 32'h300; ramstate = S_BUSY;
    cyc();
    cyc(); cyc();
    sample(); check("t4_c3_noerr", err, 0); advance();
    sample(); check("t4_err", err, 1); check("t4_dload", dload, BAD); check("t4_dwait", dwait, 0); advance();
    dREN = 0;
    sample(); check("t4_idle", ramREN, 0); check("t4_err_gone", err, 0); advance();

    // 5: imem abort mid-grant
    iREN = 1; iaddr = 32'h80;
    cyc();
    sample(); check("t5_granted", ramREN, 1); advance();
    iREN = 0;
    sample(); check("t5_abort_noerr", err, 0); advance();
    sample(); check("t5_ramREN_low", ramREN, 0); check("t5_err", err, 0); advance();

    // 6: reset mid-DGNT, then a normal grant
    dREN = 1; daddr = 32'h500;
    cyc();
    sample(); check("t6_granted", ramaddr, 32'h500); advance();
    nRST = 0; cyc();
    nRST = 1; dREN = 0;
    sample(); check("t6_ramREN", ramREN, 0); check("t6_ramaddr", ramaddr, 0); check("t6_err", err, 0); advance();
    iREN = 1; iaddr = 32'h90; ramstate = S_FREE;
    cyc();
    ramstate = S_ACC; ramload = 32'h5;
    sample(); check("t6_regrant_addr", ramaddr, 32'h90); check("t6_regrant_iload", iload, 32'h5); advance();
    iREN = 0; ramstate = S_FREE; cyc();

    // Randomized traffic with requests mostly held, aborts, errors, timeouts and resets
    for (int n = 0; n < 600; n++) begin
      int r;
      nRST = ($urandom_range(0, 99) >= 3);
      if ($urandom_range(0, 3) == 0) begin
        iREN = ($urandom_range(0, 9) < 6);
        dREN = ($urandom_range(0, 9) < 4);
        dWEN = ($urandom_range(0, 9) < 3);
        iaddr  = $urandom;
        daddr  = $urandom;
        dstore = $urandom;
      end
      ramload = $urandom;
      r = $urandom_range(0, 9);
      ramstate = (r < 3) ? S_ACC : (r < 7) ? S_BUSY : (r < 9) ? S_FREE : S_ERR;
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
